// File: rtl/sp_mul_arbiter_pkg.sv
// Shared definitions for the sp_* arbiters.
//   arb_state_e : 2-bit FSM encoding for the grant/start/wait/done sequence
//   rr_scan     : round-robin scan. Returns the first set request at or after
//                 ptr, wrapping modulo num_ports. Returns 0 when nothing is set,
//                 so callers qualify the result with |req.
package sp_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Widest requester vector the shared scan supports; narrower callers zero-extend.
  localparam int unsigned RR_MAX_PORTS = 32;
  localparam int unsigned RR_PTR_W     = $clog2(RR_MAX_PORTS);

  function automatic int unsigned rr_scan(
    input logic [RR_MAX_PORTS-1:0] req,
    input int unsigned             num_ports,
    input int unsigned             ptr
  );
    int unsigned         p;
    logic [RR_PTR_W-1:0] p_idx;
    logic                found;
    rr_scan = 0;
    found   = 1'b0;
    p       = 0;
    p_idx   = '0;
    for (int unsigned k = 0; k < RR_MAX_PORTS; k++) begin
      if ((k < num_ports) && !found) begin
        p = ptr + k;
        if (p >= num_ports) p = p - num_ports;
        p_idx = RR_PTR_W'(p);
        if (req[p_idx]) begin
          rr_scan = p;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/sp_mul_plat.sv
// Multi-cycle shift-and-add multiplier, SHIFT multiplier bits retired per cycle.
//   start_in  : one-cycle pulse, samples a_in/b_in and restarts the operation
//   ready_out : rises when c_out holds the product, stays high until next start
//   c_out     : product a_in*b_in truncated to OUTPUT_WIDTH
// No reset: a fresh start always reinitialises every register that matters, so
// callers only ever trust ready_out after their own start pulse.
module sp_mul_plat #(
  parameter int WIDTH        = 24,
  parameter int OUTPUT_WIDTH = WIDTH * 2,
  parameter int SHIFT        = 1
) (
  input  logic                    clk,
  input  logic                    start_in,
  input  logic [WIDTH-1:0]        a_in,
  input  logic [WIDTH-1:0]        b_in,
  output logic                    ready_out,
  output logic [OUTPUT_WIDTH-1:0] c_out
);

  localparam int STEPS = (WIDTH + SHIFT - 1) / SHIFT;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [OUTPUT_WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]        b_sh;
  logic [CNT_W-1:0]        cnt;
  logic [OUTPUT_WIDTH-1:0] partial;

  // Partial product of the shifted multiplicand with the next SHIFT multiplier bits.
  always_comb partial = a_sh * OUTPUT_WIDTH'(b_sh[SHIFT-1:0]);

  // cnt is a down-counter of remaining steps; zero means idle.
  always_ff @(posedge clk) begin
    if (start_in) begin
      a_sh      <= OUTPUT_WIDTH'(a_in);
      b_sh      <= b_in;
      c_out     <= '0;
      cnt       <= CNT_W'(STEPS);
      ready_out <= 1'b0;
    end else if (cnt != '0) begin
      c_out <= c_out + partial;
      a_sh  <= a_sh << SHIFT;
      b_sh  <= b_sh >> SHIFT;
      cnt   <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) ready_out <= 1'b1;
    end
  end

endmodule

// File: rtl/sp_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   rr_ptr : highest-priority port for this scan
//   grant  : one-hot winner, all zero when no request is set
//   idx    : winner index (meaningful only when |req)
module sp_rr_pick
  import sp_mul_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

  logic [RR_MAX_PORTS-1:0] req_ext;

  always_comb begin
    req_ext = RR_MAX_PORTS'(req);
    idx     = IDX_W'(rr_scan(req_ext, NUM_PORTS, 32'(rr_ptr)));
    grant   = (|req) ? (NUM_PORTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/sp_mul_arbiter.sv
// Shares one sp_mul_plat multiplier among NUM_PORTS requesters, round-robin.
//   clk, rst   : clock, synchronous active-high reset
//   req_in     : per-port request, held until ack
//   a_in, b_in : per-port operands, port i at [i*WIDTH +: WIDTH]
//   ack_out    : one-cycle pulse to the owner when c_out holds its product
//   c_out      : product, qualify with ack_out
//   grant_out  : one-hot current owner, zero when idle
//   busy_out   : high from grant through the ack cycle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; arbitrate and latch winner's operands
// ST_START | pulse multiplier start (its stale ready is not looked at)
// ST_WAIT  | wait for multiplier ready, then capture product
// ST_DONE  | ack_out pulses; grant/busy drop on the next edge
module sp_mul_arbiter
  import sp_mul_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int WIDTH        = 24,
  parameter int OUTPUT_WIDTH = WIDTH * 2,
  parameter int SHIFT        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req_in,
  input  logic [NUM_PORTS*WIDTH-1:0] a_in,
  input  logic [NUM_PORTS*WIDTH-1:0] b_in,
  output logic [NUM_PORTS-1:0]       ack_out,
  output logic [OUTPUT_WIDTH-1:0]    c_out,
  output logic [NUM_PORTS-1:0]       grant_out,
  output logic                       busy_out
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]    pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic [WIDTH-1:0]        a_sel, b_sel, a_lat, b_lat;
  logic                    latch_ops;
  logic                    mul_start, mul_ready;
  logic [OUTPUT_WIDTH-1:0] mul_c;
  logic [NUM_PORTS-1:0]    ack_d, grant_d;
  logic                    busy_d;
  logic [OUTPUT_WIDTH-1:0] c_d;

  sp_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req    (req_in),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  sp_mul_plat #(
    .WIDTH        (WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .SHIFT        (SHIFT)
  ) u_mul (
    .clk       (clk),
    .start_in  (mul_start),
    .a_in      (a_lat),
    .b_in      (b_lat),
    .ready_out (mul_ready),
    .c_out     (mul_c)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req_in) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (mul_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d     = '0;
    grant_d   = grant_out;
    busy_d    = busy_out;
    c_d       = c_out;
    rr_ptr_d  = rr_ptr_q;
    latch_ops = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_in) begin
          grant_d   = pick_grant;
          busy_d    = 1'b1;
          latch_ops = 1'b1;
          // Winner drops to lowest priority for the next scan.
          rr_ptr_d  = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ST_START: mul_start = 1'b1;
      ST_WAIT: begin
        if (mul_ready) begin
          c_d   = mul_c;
          // grant_out is one-hot, so the ack can only reach the owner.
          ack_d = grant_out;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_out   <= '0;
      c_out     <= '0;
      grant_out <= '0;
      busy_out  <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      ack_out   <= ack_d;
      c_out     <= c_d;
      grant_out <= grant_d;
      busy_out  <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Operand copies need no reset: they are only consumed after a fresh latch.
  always_ff @(posedge clk) begin
    if (latch_ops) begin
      a_lat <= a_sel;
      b_lat <= b_sel;
    end
  end

endmodule

// File: tb/tb_sp_mul_arbiter.sv
module tb_sp_mul_arbiter;

  localparam int NP  = 4;
  localparam int W   = 8;
  localparam int OW  = 16;
  localparam int SH  = 1;
  localparam int L   = (W + SH - 1) / SH;
  localparam int LAT_FIRST = 3 + L;   // req set while idle -> ack tick
  localparam int LAT_NEXT  = 4 + L;   // ack tick -> next ack tick
  localparam int BUDGET    = 4 * (4 + L);

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req_in;
  logic [NP*W-1:0] a_in, b_in;
  logic [NP-1:0]   ack_out;
  logic [OW-1:0]   c_out;
  logic [NP-1:0]   grant_out;
  logic            busy_out;

  int n_checks = 0;
  int n_fail   = 0;
  int model_rr = 0;
  int ma [NP];
  int mb [NP];

  sp_mul_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .OUTPUT_WIDTH(OW), .SHIFT(SH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack_out   (ack_out),
    .c_out     (c_out),
    .grant_out (grant_out),
    .busy_out  (busy_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int p, input int a, input int b);
    ma[p] = a;
    mb[p] = b;
    a_in[p*W +: W] = W'(a);
    b_in[p*W +: W] = W'(b);
  endtask

  // Reference arbitration: first pending port at or after rr, wrapping.
  function automatic int model_pick(input logic [NP-1:0] pend, input int rr);
    int p;
    for (int k = 0; k < NP; k++) begin
      p = (rr + k) % NP;
      if (pend[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] model_prod(input int a, input int b);
    return OW'(a * b);
  endfunction

  // Collects the next ack: its port, product, tick count, grant at that moment
  // and how many extra ack bits were high. port=-1 on timeout.
  task automatic wait_ack(input int budget, output int port, output logic [OW-1:0] c,
                          output int lat, output logic [NP-1:0] grant_at, output int extra);
    bit found;
    found = 0; port = -1; c = '0; lat = -1; grant_at = '0; extra = 0;
    for (int k = 1; k <= budget && !found; k++) begin
      tick();
      if (ack_out != '0) begin
        found    = 1;
        lat      = k;
        c        = c_out;
        grant_at = grant_out;
        extra    = $countones(ack_out) - 1;
        for (int i = 0; i < NP; i++) if (ack_out[i]) port = i;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_in = '1;
    for (int i = 0; i < NP; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (3) tick();
    n_checks++; if (ack_out !== '0)   begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_out); end
    n_checks++; if (c_out !== '0)     begin n_fail++; $display("FAIL reset_c: got %h want 0", c_out); end
    n_checks++; if (grant_out !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant_out); end
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    req_in = '0;
    rst = 1'b0;
    model_rr = 0;
    repeat (2) tick();
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_out); end
  endtask

  task automatic test_single;
    int port, lat, extra;
    logic [OW-1:0] c;
    logic [NP-1:0] g;
    set_ops(2, 3, 5);
    req_in = 4'b0100;
    tick();
    n_checks++; if (grant_out !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant_out); end
    n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy_out); end
    wait_ack(BUDGET, port, c, lat, g, extra);
    req_in = '0;
    n_checks++; if (port !== 2) begin n_fail++; $display("FAIL single_port: got %0d want 2", port); end
    n_checks++; if (c !== 16'd15) begin n_fail++; $display("FAIL single_c: got %0d want 15", c); end
    n_checks++; if (lat !== LAT_FIRST - 1) begin n_fail++; $display("FAIL single_lat: got %0d want %0d", lat, LAT_FIRST - 1); end
    tick();
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy_out); end
    n_checks++; if (grant_out !== '0) begin n_fail++; $display("FAIL single_grant_after: got %b want 0", grant_out); end
    n_checks++; if (ack_out !== '0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", ack_out); end
    model_rr = 3;
  endtask

  task automatic test_all_four;
    int port, lat, extra, exp_p;
    logic [OW-1:0] c;
    logic [NP-1:0] g, pend;
    rst = 1'b1; tick(); rst = 1'b0;
    model_rr = 0;
    for (int i = 0; i < NP; i++) set_ops(i, i + 1, 10);
    pend = '1;
    req_in = pend;
    for (int n = 0; n < NP; n++) begin
      exp_p = model_pick(pend, model_rr);
      wait_ack(BUDGET, port, c, lat, g, extra);
      n_checks++; if (port !== n) begin n_fail++; $display("FAIL all4_order: got %0d want %0d", port, n); end
      n_checks++; if (c !== model_prod(ma[exp_p], mb[exp_p])) begin n_fail++; $display("FAIL all4_c: got %0d want %0d", c, model_prod(ma[exp_p], mb[exp_p])); end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL all4_multi_ack: got %0d extra acks want 0", extra); end
      n_checks++; if (lat !== ((n == 0) ? LAT_FIRST : LAT_NEXT)) begin n_fail++; $display("FAIL all4_lat: got %0d want %0d", lat, (n == 0) ? LAT_FIRST : LAT_NEXT); end
      pend[exp_p] = 1'b0;
      req_in = pend;
      model_rr = (exp_p + 1) % NP;
      if (port < 0) break;
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_alternate;
    int port, lat, extra, exp_p, prev;
    logic [OW-1:0] c, ep;
    logic [NP-1:0] g, pend;
    pend = 4'b1010;
    set_ops(1, $urandom_range(0, 255), $urandom_range(0, 255));
    set_ops(3, $urandom_range(0, 255), $urandom_range(0, 255));
    req_in = pend;
    prev = -1;
    for (int n = 0; n < 6; n++) begin
      exp_p = model_pick(pend, model_rr);
      ep = model_prod(ma[exp_p], mb[exp_p]);
      wait_ack(BUDGET, port, c, lat, g, extra);
      n_checks++; if (port !== exp_p) begin n_fail++; $display("FAIL alt_port: got %0d want %0d", port, exp_p); end
      n_checks++; if (port == prev) begin n_fail++; $display("FAIL alt_repeat: port %0d won twice, want alternation", port); end
      n_checks++; if (c !== ep) begin n_fail++; $display("FAIL alt_c: got %0d want %0d", c, ep); end
      n_checks++; if (lat !== ((n == 0) ? LAT_FIRST : LAT_NEXT)) begin n_fail++; $display("FAIL alt_lat: got %0d want %0d", lat, (n == 0) ? LAT_FIRST : LAT_NEXT); end
      set_ops(exp_p, $urandom_range(0, 255), $urandom_range(0, 255));
      model_rr = (exp_p + 1) % NP;
      prev = port;
      if (port < 0) break;
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_max_and_operand_change;
    int port, lat, extra;
    logic [OW-1:0] c;
    logic [NP-1:0] g;
    set_ops(0, 8'hFF, 8'hFF);
    req_in = 4'b0001;
    repeat (4) tick();
    a_in[0 +: W] = 8'h12;
    b_in[0 +: W] = 8'h34;
    wait_ack(BUDGET, port, c, lat, g, extra);
    req_in = '0;
    n_checks++; if (port !== 0) begin n_fail++; $display("FAIL max_port: got %0d want 0", port); end
    n_checks++; if (c !== 16'hFE01) begin n_fail++; $display("FAIL max_c: got %h want fe01", c); end
    n_checks++; if (lat !== LAT_FIRST - 4) begin n_fail++; $display("FAIL max_lat: got %0d want %0d", lat, LAT_FIRST - 4); end
    model_rr = 1;
    tick();
  endtask

  task automatic test_reset_mid;
    int port, lat, extra, n_ack1;
    logic [OW-1:0] c;
    logic [NP-1:0] g;
    set_ops(1, $urandom_range(1, 255), $urandom_range(1, 255));
    req_in = 4'b0010;
    n_ack1 = 0;
    repeat (4) begin tick(); if (ack_out[1]) n_ack1++; end
    n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", busy_out); end
    rst = 1'b1;
    tick();
    if (ack_out[1]) n_ack1++;
    rst = 1'b0;
    n_checks++; if (grant_out !== '0) begin n_fail++; $display("FAIL rmid_grant: got %b want 0", grant_out); end
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy_out); end
    n_checks++; if (n_ack1 !== 0) begin n_fail++; $display("FAIL rmid_no_ack: got %0d acks want 0", n_ack1); end
    model_rr = 0;
    set_ops(0, $urandom_range(0, 255), $urandom_range(0, 255));
    req_in = 4'b0011;
    wait_ack(BUDGET, port, c, lat, g, extra);
    req_in = 4'b0010;
    n_checks++; if (port !== 0) begin n_fail++; $display("FAIL rmid_first: got %0d want 0", port); end
    n_checks++; if (c !== model_prod(ma[0], mb[0])) begin n_fail++; $display("FAIL rmid_c0: got %0d want %0d", c, model_prod(ma[0], mb[0])); end
    n_checks++; if (lat !== LAT_FIRST) begin n_fail++; $display("FAIL rmid_lat: got %0d want %0d", lat, LAT_FIRST); end
    wait_ack(BUDGET, port, c, lat, g, extra);
    req_in = '0;
    n_checks++; if (port !== 1) begin n_fail++; $display("FAIL rmid_second: got %0d want 1", port); end
    n_checks++; if (c !== model_prod(ma[1], mb[1])) begin n_fail++; $display("FAIL rmid_c1: got %0d want %0d", c, model_prod(ma[1], mb[1])); end
    model_rr = 2;
    tick();
  endtask

  task automatic test_drop_in_wait;
    int port, lat, extra, n_extra_acks;
    logic [OW-1:0] c;
    logic [NP-1:0] g;
    set_ops(2, $urandom_range(0, 255), $urandom_range(0, 255));
    req_in = 4'b0100;
    repeat (4) tick();
    req_in = '0;
    wait_ack(BUDGET, port, c, lat, g, extra);
    n_checks++; if (port !== 2) begin n_fail++; $display("FAIL drop_port: got %0d want 2", port); end
    n_checks++; if (c !== model_prod(ma[2], mb[2])) begin n_fail++; $display("FAIL drop_c: got %0d want %0d", c, model_prod(ma[2], mb[2])); end
    n_checks++; if (lat !== LAT_FIRST - 4) begin n_fail++; $display("FAIL drop_lat: got %0d want %0d", lat, LAT_FIRST - 4); end
    n_extra_acks = 0;
    repeat (2 * LAT_NEXT) begin tick(); if (ack_out != '0) n_extra_acks++; end
    n_checks++; if (n_extra_acks !== 0) begin n_fail++; $display("FAIL drop_single_ack: got %0d later acks want 0", n_extra_acks); end
    model_rr = 3;
  endtask

  task automatic test_random;
    int port, lat, extra, exp_p, ops;
    bit first;
    logic [OW-1:0] c, ep;
    logic [NP-1:0] g, pend, want_g;
    for (int r = 0; r < 20; r++) begin
      pend = NP'($urandom_range(1, (1 << NP) - 1));
      for (int i = 0; i < NP; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
      req_in = pend;
      first = 1;
      ops = 0;
      while (pend != '0) begin
        exp_p = model_pick(pend, model_rr);
        ep = model_prod(ma[exp_p], mb[exp_p]);
        want_g = '0;
        want_g[exp_p] = 1'b1;
        wait_ack(BUDGET, port, c, lat, g, extra);
        n_checks++; if (port !== exp_p) begin n_fail++; $display("FAIL rand_port: round %0d got %0d want %0d", r, port, exp_p); end
        n_checks++; if (c !== ep) begin n_fail++; $display("FAIL rand_c: round %0d got %0d want %0d", r, c, ep); end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rand_multi_ack: round %0d got %0d extra want 0", r, extra); end
        n_checks++; if (g !== want_g) begin n_fail++; $display("FAIL rand_grant_at_ack: round %0d got %b want %b", r, g, want_g); end
        n_checks++; if (lat !== (first ? LAT_FIRST : LAT_NEXT)) begin n_fail++; $display("FAIL rand_lat: round %0d got %0d want %0d", r, lat, first ? LAT_FIRST : LAT_NEXT); end
        first = 0;
        ops++;
        model_rr = (exp_p + 1) % NP;
        if (ops < 8 && $urandom_range(0, 2) == 0)
          set_ops(exp_p, $urandom_range(0, 255), $urandom_range(0, 255));
        else
          pend[exp_p] = 1'b0;
        req_in = pend;
        if (port < 0) pend = '0;
      end
      req_in = '0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_in = '0;
    a_in = '0;
    b_in = '0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_max_and_operand_change();
    test_reset_mid();
    test_drop_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
